// File: rtl/cdb_arbiter_pkg.sv
// Shared parameters for the common data bus arbiter and the reorder buffer.
// Also hosts the saturating adder used by the optional stall statistics (CDB_ARB_STATS_EN).
package cdb_arbiter_pkg;

    localparam int unsigned FU_NUM    = 8;
    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned RB_INDEX  = 3;
    localparam int unsigned FU_INDEX  = 4;

    // All-ones FU code is reserved to mean "nobody is broadcasting".
    localparam logic [FU_INDEX-1:0] NO_FU = '1;

    localparam int unsigned STALL_W = 16;

    function automatic logic [STALL_W-1:0] sat_add16(
        input logic [STALL_W-1:0] a,
        input logic [STALL_W-1:0] b
    );
        logic [STALL_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[STALL_W] ? '1 : sum[STALL_W-1:0];
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin picker: first set bit of elig_i at or above ptr_i, wrapping modulo N.
// Shared by the CDB arbiter and the issue logic.
module rr_picker #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 4
) (
    input  logic [N-1:0]     elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned off);
        return (base + off) % N;
    endfunction

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!any_o && elig_i[wrap_idx(32'(ptr_i), k)]) begin
                any_o                            = 1'b1;
                idx_o                            = IDX_W'(wrap_idx(32'(ptr_i), k));
                gnt_o[wrap_idx(32'(ptr_i), k)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among FUs, registered one-cycle-later broadcast.
// Optional stall counter output enabled by defining CDB_ARB_STATS_EN.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned FU_NUM    = cdb_arbiter_pkg::FU_NUM,
    parameter int unsigned WORD_SIZE = cdb_arbiter_pkg::WORD_SIZE,
    parameter int unsigned RB_INDEX  = cdb_arbiter_pkg::RB_INDEX,
    parameter int unsigned FU_INDEX  = cdb_arbiter_pkg::FU_INDEX
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FU_NUM-1:0]             req,
    input  logic [FU_NUM*WORD_SIZE-1:0]   req_data,
    input  logic [FU_NUM*WORD_SIZE-1:0]   req_addr,
    input  logic [FU_NUM*RB_INDEX-1:0]    req_rbidx,
    input  logic [FU_NUM-1:0]             flush,
    output logic [FU_NUM-1:0]             gnt,
    output logic                          cdb_valid,
    output logic [WORD_SIZE-1:0]          cdb_data,
    output logic [WORD_SIZE-1:0]          cdb_addr,
    output logic [RB_INDEX-1:0]           cdb_rbidx,
    output logic [FU_INDEX-1:0]           cdb_fu
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    logic [FU_NUM-1:0]    elig;
    logic [FU_NUM-1:0]    pick_gnt;
    logic [FU_INDEX-1:0]  pick_idx;
    logic                 pick_any;

    logic [FU_INDEX-1:0]  ptr_q, ptr_d;
    logic                 cdb_valid_q;
    logic [WORD_SIZE-1:0] cdb_data_q, cdb_data_d;
    logic [WORD_SIZE-1:0] cdb_addr_q, cdb_addr_d;
    logic [RB_INDEX-1:0]  cdb_rbidx_q, cdb_rbidx_d;
    logic [FU_INDEX-1:0]  cdb_fu_q;

    assign elig = req & ~flush;

    rr_picker #(
        .N     (FU_NUM),
        .IDX_W (FU_INDEX)
    ) u_picker (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign gnt = reset ? '0 : pick_gnt;

    // Grant is one-hot, so OR-ing the masked payloads selects the winner's word.
    always_comb begin
        cdb_data_d  = '0;
        cdb_addr_d  = '0;
        cdb_rbidx_d = '0;
        for (int unsigned i = 0; i < FU_NUM; i++) begin
            if (pick_gnt[i]) begin
                cdb_data_d  = cdb_data_d  | req_data[i*WORD_SIZE +: WORD_SIZE];
                cdb_addr_d  = cdb_addr_d  | req_addr[i*WORD_SIZE +: WORD_SIZE];
                cdb_rbidx_d = cdb_rbidx_d | req_rbidx[i*RB_INDEX +: RB_INDEX];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (pick_any) begin
            ptr_d = (pick_idx == FU_INDEX'(FU_NUM - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_addr_q  <= '0;
            cdb_rbidx_q <= '0;
            cdb_fu_q    <= NO_FU;
        end else begin
            ptr_q       <= ptr_d;
            cdb_valid_q <= pick_any;
            if (pick_any) begin
                cdb_data_q  <= cdb_data_d;
                cdb_addr_q  <= cdb_addr_d;
                cdb_rbidx_q <= cdb_rbidx_d;
                cdb_fu_q    <= pick_idx;
            end else begin
                cdb_fu_q    <= NO_FU;
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_addr  = cdb_addr_q;
    assign cdb_rbidx = cdb_rbidx_q;
    assign cdb_fu    = cdb_fu_q;

`ifdef CDB_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic [15:0] losers;

    // Every eligible FU except the winner lost this cycle.
    always_comb begin
        losers = '0;
        for (int unsigned i = 0; i < FU_NUM; i++) begin
            losers = losers + 16'(elig[i]);
        end
        if (pick_any) begin
            losers = losers - 16'd1;
        end
        stall_d = sat_add16(stall_q, losers);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
